// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for the tx arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_arb_pkg;

    // Arbiter FSM states: waiting for a requester, or owned by one requester.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Byte width shared with the tx pipe.
    localparam int DEF_WIDTH = 8;

endpackage : tx_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after last, wrapping N-1 -> 0.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          any
);

    int idx;

    // Scan from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        pick = '0;
        any  = |req;
        idx  = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/tx_arbiter.sv
// Message-granular round-robin arbiter feeding one tx pipe byte stream.
// Latency: grant one cycle after request; bytes pass through combinationally.
// Backpressure: pipe_full drops the owner's req_ready and pipe_push same cycle.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_LEN = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       pipe_full,
    output logic                       pipe_push,
    output logic [WIDTH-1:0]           pipe_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  grant_q;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       last_owner;
    logic [CW-1:0]       cnt;

    logic [NUM_REQ-1:0]  pick;
    logic                pick_any;
    logic [IW-1:0]       pick_idx;
    logic                xfer;
    logic                done;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req  (req_valid),
        .last (last_owner),
        .pick (pick),
        .any  (pick_any)
    );

    // Convert the one-hot pick into an index for slicing the data bus.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    // A transfer happens only for the owner and only when the pipe has room;
    // the message ends on its last byte or when the length cap is hit.
    always_comb begin
        xfer = (state == LOCKED) && req_valid[owner] && !pipe_full;
        done = xfer && (req_last[owner] || (cnt == CW'(MAX_LEN - 1)));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = LOCKED;
            LOCKED:  if (done)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner-facing and pipe-facing outputs; everything is quiet outside LOCKED.
    always_comb begin
        busy      = (state == LOCKED);
        grant     = grant_q;
        req_ready = (busy && !pipe_full) ? grant_q : '0;
        pipe_push = xfer;
        pipe_data = busy ? req_data[int'(owner)*WIDTH +: WIDTH] : '0;
    end

    // Grant, owner history and byte counter; last_owner starts at the top
    // index so requester 0 wins the first arbitration after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= '0;
            owner      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            cnt        <= '0;
        end else if (state == IDLE) begin
            if (pick_any) begin
                grant_q <= pick;
                owner   <= pick_idx;
                cnt     <= '0;
            end
        end else if (xfer) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                grant_q    <= '0;
                last_owner <= owner;
            end
        end
    end

endmodule : tx_arbiter

// File: tb/tb_tx_arbiter.sv
// Randomised and directed bench for tx_arbiter against a message-level model.
// Latency: n/a.
// Backpressure: pipe_full driven by the bench.
module tb_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ML = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             pipe_full;
    logic             pipe_push;
    logic [W-1:0]     pipe_data;
    logic [N-1:0]     grant;
    logic             busy;

    tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_LEN(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .pipe_full (pipe_full),
        .pipe_push (pipe_push),
        .pipe_data (pipe_data),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Per-requester source queues of {last, byte}.
    logic [8:0]  src_q [N][$];
    logic [N-1:0] stall;

    // Reference model: current owner (-1 idle), previous owner, bytes sent.
    int m_owner;
    int m_last;
    int m_cnt;

    int          grant_log[$];
    int          out_own[$];
    logic [7:0]  out_dat[$];
    int          out_cyc[$];
    logic [N-1:0] prev_grant;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < N; i++) src_q[i].delete();
        grant_log.delete();
        out_own.delete();
        out_dat.delete();
        out_cyc.delete();
        stall = '0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_cnt   = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 && !stall[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*W +: W]  = src_q[i][0][7:0];
                req_last[i]         = src_q[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*W +: W]  = W'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
    endtask

    // One clock: drive, check outputs at the falling edge, advance the model.
    task automatic cycle();
        logic [N-1:0] e_grant, e_ready;
        logic         e_push, e_busy;
        logic [8:0]   ent;
        drive_inputs();
        @(negedge clk);
        e_grant = '0; e_ready = '0; e_push = 1'b0; e_busy = 1'b0;
        if (!rst && m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_busy           = 1'b1;
            e_ready          = pipe_full ? '0 : e_grant;
            e_push           = req_valid[m_owner] && !pipe_full;
        end
        checks++;
        if (grant !== e_grant) begin
            failures++;
            $display("FAIL grant: got %b want %b (cycle %0d)", grant, e_grant, cyc);
        end
        checks++;
        if (busy !== e_busy) begin
            failures++;
            $display("FAIL busy: got %b want %b (cycle %0d)", busy, e_busy, cyc);
        end
        checks++;
        if (req_ready !== e_ready) begin
            failures++;
            $display("FAIL req_ready: got %b want %b (cycle %0d)", req_ready, e_ready, cyc);
        end
        checks++;
        if (pipe_push !== e_push) begin
            failures++;
            $display("FAIL pipe_push: got %b want %b (cycle %0d)", pipe_push, e_push, cyc);
        end
        if (e_push) begin
            checks++;
            if (pipe_data !== src_q[m_owner][0][7:0]) begin
                failures++;
                $display("FAIL pipe_data: got %h want %h (cycle %0d)", pipe_data, src_q[m_owner][0][7:0], cyc);
            end
        end
        if (pipe_push === 1'b1) begin
            out_own.push_back(oh_idx(grant));
            out_dat.push_back(pipe_data);
            out_cyc.push_back(cyc);
        end
        if (grant != '0 && prev_grant == '0) grant_log.push_back(oh_idx(grant));
        prev_grant = grant;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
            end
            m_cnt = 0;
        end else if (e_push) begin
            ent = src_q[m_owner].pop_front();
            m_cnt++;
            if (ent[8] || m_cnt == ML) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input int budget, input bit need_idle);
        int c = 0;
        while ((!queues_empty() || (need_idle && m_owner >= 0)) && c < budget) begin
            cycle();
            c++;
        end
        checks++;
        if (c >= budget) begin
            failures++;
            $display("FAIL drain_timeout: got %0d cycles, required under %0d", c, budget);
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        pipe_full = 1'b0;
        clear_all();
        model_reset();
        cycle();
        cycle();
        rst        = 1'b0;
        prev_grant = '0;
        clear_all();
    endtask

    task automatic push_msg(input int r, input int len, input logic [7:0] base, input bit with_last);
        for (int b = 0; b < len; b++)
            src_q[r].push_back({(with_last && b == len - 1), 8'(base + b)});
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        pipe_full = 1'b0;
        clear_all();
        model_reset();
        for (int i = 0; i < N; i++) push_msg(i, 2, 8'h00, 1'b1);
        drive_inputs();
        #2;
        checks++;
        if (grant !== '0 || busy !== 1'b0 || req_ready !== '0 || pipe_push !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got grant=%b busy=%b ready=%b push=%b, want all zero",
                     grant, busy, req_ready, pipe_push);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        src_q[1].push_back({1'b0, 8'h41});
        src_q[1].push_back({1'b0, 8'h42});
        src_q[1].push_back({1'b1, 8'h43});
        drain(20, 1'b1);
        checks++;
        if (grant_log.size() != 1 || grant_log[0] != 1) begin
            failures++;
            $display("FAIL single_grant: got %0d grants (first %0d), want one grant to 1",
                     grant_log.size(), grant_log.size() ? grant_log[0] : -1);
        end
        checks++;
        if (out_dat.size() != 3 || out_dat[0] != 8'h41 || out_dat[1] != 8'h42 || out_dat[2] != 8'h43) begin
            failures++;
            $display("FAIL single_bytes: got %0d bytes, want 41 42 43", out_dat.size());
        end else begin
            checks++;
            if (out_cyc[2] - out_cyc[0] != 2) begin
                failures++;
                $display("FAIL single_contiguous: got span %0d, want 2", out_cyc[2] - out_cyc[0]);
            end
        end
    endtask

    task automatic test_fairness();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < N; i++) begin
            push_msg(i, 2, 8'(i * 16), 1'b1);
            push_msg(i, 2, 8'(i * 16 + 8), 1'b1);
        end
        drain(100, 1'b1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= grant_log.size() || grant_log[k] != exp_order[k]) begin
                failures++;
                $display("FAIL fair_order[%0d]: got %0d want %0d", k,
                         k < grant_log.size() ? grant_log[k] : -1, exp_order[k]);
            end
        end
        checks++;
        if (out_own.size() != 16) begin
            failures++;
            $display("FAIL fair_count: got %0d want 16", out_own.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (out_own[2*k] != out_own[2*k+1]) begin
                    failures++;
                    $display("FAIL fair_contig[%0d]: got owners %0d,%0d want equal", k, out_own[2*k], out_own[2*k+1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n_before;
        apply_reset();
        push_msg(2, 4, 8'h10, 1'b1);
        repeat (3) cycle();
        n_before  = out_dat.size();
        pipe_full = 1'b1;
        repeat (5) cycle();
        checks++;
        if (out_dat.size() != n_before) begin
            failures++;
            $display("FAIL bp_no_push: got %0d pushes while full, want 0", out_dat.size() - n_before);
        end
        pipe_full = 1'b0;
        drain(20, 1'b1);
        checks++;
        if (out_dat.size() != 4 || out_dat[0] != 8'h10 || out_dat[1] != 8'h11 ||
            out_dat[2] != 8'h12 || out_dat[3] != 8'h13) begin
            failures++;
            $display("FAIL bp_bytes: got %0d bytes, want 10 11 12 13", out_dat.size());
        end
    endtask

    task automatic test_forced();
        apply_reset();
        push_msg(0, 10, 8'hA0, 1'b0);
        push_msg(2, 2, 8'hB0, 1'b1);
        drain(60, 1'b0);
        repeat (2) cycle();
        checks++;
        if (grant_log.size() < 3 || grant_log[0] != 0 || grant_log[1] != 2 || grant_log[2] != 0) begin
            failures++;
            $display("FAIL forced_order: got %0d grants, want 0,2,0 first", grant_log.size());
        end
        checks++;
        if (out_dat.size() != 12 || out_own[3] != 0 || out_dat[3] != 8'hA3 ||
            out_own[4] != 2 || out_dat[4] != 8'hB0 || out_own[6] != 0 || out_dat[6] != 8'hA4) begin
            failures++;
            $display("FAIL forced_split: got %0d bytes, want A0-A3 then B0,B1 then A4..", out_dat.size());
        end
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL forced_hold: got %b want 0001", grant);
        end
    endtask

    task automatic test_stall();
        int n_before;
        apply_reset();
        push_msg(0, 4, 8'hC0, 1'b1);
        push_msg(3, 1, 8'hD0, 1'b1);
        repeat (3) cycle();
        n_before = out_dat.size();
        stall[0] = 1'b1;
        repeat (3) begin
            cycle();
            checks++;
            if (grant !== 4'b0001) begin
                failures++;
                $display("FAIL stall_grant: got %b want 0001", grant);
            end
        end
        checks++;
        if (out_dat.size() != n_before) begin
            failures++;
            $display("FAIL stall_push: got %0d extra pushes want 0", out_dat.size() - n_before);
        end
        stall[0] = 1'b0;
        drain(30, 1'b1);
        checks++;
        if (out_dat.size() != 5 || out_dat[3] != 8'hC3 || out_own[3] != 0 ||
            out_dat[4] != 8'hD0 || out_own[4] != 3) begin
            failures++;
            $display("FAIL stall_bytes: got %0d bytes, want C0-C3 then D0", out_dat.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push_msg(1, 3, 8'hE0, 1'b1);
        repeat (2) cycle();
        drive_inputs();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0 || req_ready !== '0 || pipe_push !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got grant=%b busy=%b ready=%b push=%b want zeros",
                     grant, busy, req_ready, pipe_push);
        end
        model_reset();
        clear_all();
        cycle();
        rst        = 1'b0;
        prev_grant = '0;
        push_msg(1, 1, 8'hF0, 1'b1);
        push_msg(0, 1, 8'h70, 1'b1);
        drain(20, 1'b1);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            failures++;
            $display("FAIL reset_rr: got %0d grants (first %0d), want 0 then 1",
                     grant_log.size(), grant_log.size() ? grant_log[0] : -1);
        end
        checks++;
        if (out_dat.size() != 2 || out_dat[0] != 8'h70 || out_dat[1] != 8'hF0) begin
            failures++;
            $display("FAIL reset_bytes: got %0d bytes want 70 F0", out_dat.size());
        end
    endtask

    task automatic test_random();
        int sent = 0;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            int r;
            int len;
            r = $urandom_range(N - 1);
            if (src_q[r].size() < 6 && $urandom_range(3) == 0) begin
                len = $urandom_range(6, 1);
                push_msg(r, len, 8'($urandom), 1'b1);
                sent += len;
            end
            pipe_full = ($urandom_range(3) == 0);
            for (int i = 0; i < N; i++) stall[i] = ($urandom_range(9) == 0);
            cycle();
        end
        pipe_full = 1'b0;
        stall     = '0;
        drain(400, 1'b1);
        checks++;
        if (out_dat.size() != sent) begin
            failures++;
            $display("FAIL random_total: got %0d bytes want %0d", out_dat.size(), sent);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pipe_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        stall     = '0;
        prev_grant = '0;
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_forced();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tx_arbiter
